ulpi_reg_arb: RTL and testbench
===============================

Name: ulpi_reg_arb

Overview:
- Register-access engine that sits beside ulpi_ctrl.
- Accepts ULPI PHY register read/write requests from N_REQ internal requesters and arbitrates them round-robin.
- Sequences each ULPI register transaction on the link side: TX CMD, nxt/dir handshakes, stp, bus turnaround.
- ulpi_ctrl muxes this block's o_data/o_stp onto the ULPI pins whenever o_busy=1.

Parameters:
N_REQ, 2, number of requesters (1..8)
TIMEOUT, 64, max cycles allowed in any bus-active state before abort with error

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_req  in  N_REQ  per-requester request; held until o_gnt bit seen
i_we  in  N_REQ  1=register write, 0=register read
i_addr  in  N_REQ*6  per-requester register address; slice k = bits [6k+5:6k]
i_wdata  in  N_REQ*8  per-requester write data
o_gnt  out  N_REQ  one-hot, 1-cycle pulse; operands captured this cycle
o_done  out  N_REQ  one-hot, 1-cycle completion pulse to the owning requester
o_err  out  1  valid with o_done; 1 = timeout
o_rdata  out  8  read result; valid with o_done, holds until next read completes
o_busy  out  1  high in every state except IDLE
i_dir  in  1  ULPI dir
i_nxt  in  1  ULPI nxt
i_data  in  8  ULPI data from PHY
o_data  out  8  ULPI data to PHY
o_stp  out  1  ULPI stp

Behaviour:
- Reset: state=IDLE; rr pointer=0; o_data, o_stp, o_gnt, o_done, o_err, o_rdata, o_busy all 0; timeout counter=0.
- Reset asserted in any state returns to IDLE on the next edge. The transaction in flight is dropped with no o_done.
- All outputs are registered.
- FSM states: IDLE, TXCMD, WDATA, STP, RD_TURN, RD_DATA, RD_TURN2, RETRY, DONE.
- IDLE:
  - If i_dir=0 and any i_req: select the first requester at or after the rr pointer, wrapping modulo N_REQ.
  - Latch we/addr/wdata and owner index k; pulse o_gnt[k]; go to TXCMD.
  - o_data = {we ? 2'b10 : 2'b11, addr} from that cycle onward.
  - If i_dir=1, no grant.
- TXCMD: hold o_data.
  - i_dir=1 (PHY abort) takes priority over i_nxt: o_data=0, go to RETRY.
  - Else i_nxt=1: write goes to WDATA with o_data=wdata; read goes to RD_TURN with o_data=0.
- WDATA: hold wdata; on i_nxt=1 go to STP.
- STP: o_stp=1 and o_data=0 for exactly one cycle; then DONE.
- RD_TURN: wait for i_dir=1, then RD_DATA.
- RD_DATA: capture i_data into o_rdata; go to RD_TURN2.
- RD_TURN2: wait for i_dir=0, then DONE.
- RETRY: wait for i_dir=0, then reissue the latched TX CMD (back to TXCMD). No re-grant, no pointer change.
- DONE: pulse o_done[k] with o_err=0; rr pointer = k+1 mod N_REQ; go to IDLE.
- Timeout counter:
  - Cleared on entry to TXCMD; counts in TXCMD, WDATA, RD_TURN, RD_DATA, RD_TURN2 and RETRY.
  - At TIMEOUT-1: pulse o_done[k] with o_err=1, o_data=0, o_stp=0; advance rr pointer; go to IDLE.
- Requesters drop i_req on the edge after seeing o_gnt. The FSM samples i_req only in IDLE.
- Back-to-back: IDLE lasts at least 1 cycle between transactions.

Test Plan:
- Write, N_REQ=2: req0 we=1 addr=0x0A wdata=0x55; PHY nxt on 2nd TXCMD cycle and 1st WDATA cycle -> o_data 0x8A then 0x55; o_stp=1 for one cycle with o_data=0x00; o_done=2'b01, o_err=0.
- Read: req1 we=0 addr=0x16; nxt, then dir=1, PHY i_data=0xA3, then dir=0 -> o_data=0xD6 in TXCMD; o_rdata=0xA3; o_done=2'b10; o_stp never asserted.
- Round-robin: both reqs held high continuously from reset -> grants in order 0,1,0,1; no requester is granted twice in a row.
- Abort: dir rises during TXCMD with nxt=1 in the same cycle -> RETRY; after dir=0, TX CMD is reissued with the same byte; o_gnt is not repeated; transaction completes normally.
- Timeout: TIMEOUT=8, nxt held 0 -> o_done with o_err=1 eight cycles after TXCMD entry; o_data=0; o_busy drops the next cycle.
- Reset mid-WDATA: i_rst=1 for one edge -> all outputs 0, state IDLE, no o_done; a pending request is then granted to requester 0.

Source files
------------

// File: rtl/ulpi_reg_arb.sv
// Round-robin arbiter and link-side sequencer for ULPI PHY register reads/writes
// issued by N_REQ internal requesters; all outputs are registered.
module ulpi_reg_arb #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_we,
    input  logic [N_REQ*6-1:0] i_addr,
    input  logic [N_REQ*8-1:0] i_wdata,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_done,
    output logic               o_err,
    output logic [7:0]         o_rdata,
    output logic               o_busy,
    input  logic               i_dir,
    input  logic               i_nxt,
    input  logic [7:0]         i_data,
    output logic [7:0]         o_data,
    output logic               o_stp
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, TXCMD, WDATA, STP, RD_TURN, RD_DATA, RD_TURN2, RETRY, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            stp_q, stp_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   own_q, own_d;
    logic            we_q, we_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdbuf_q, rdbuf_d;

    logic [5:0]      addr_arr  [N_REQ];
    logic [7:0]      wdata_arr [N_REQ];
    logic [IW-1:0]   sel_idx;
    logic            sel_vld;
    logic            counting;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k]  = i_addr[6*k +: 6];
            wdata_arr[k] = i_wdata[8*k +: 8];
        end
    end

    // Scanning downward lets the lowest offset from the pointer win.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[wrap_idx(rr_q, i)]) begin
                sel_idx = wrap_idx(rr_q, i);
                sel_vld = 1'b1;
            end
        end
    end

    assign counting = state_q inside {TXCMD, WDATA, RD_TURN, RD_DATA, RD_TURN2, RETRY};

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        stp_d   = 1'b0;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        own_d   = own_q;
        we_d    = we_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdbuf_d = rdbuf_q;

        if (counting && cnt_q == TO_LAST) begin
            state_d        = IDLE;
            done_d[own_q]  = 1'b1;
            err_d          = 1'b1;
            data_d         = '0;
            rr_d           = wrap_idx(own_q, 1);
        end else begin
            if (counting) begin
                cnt_d = cnt_q + CW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    data_d = '0;
                    if (!i_dir && sel_vld) begin
                        own_d          = sel_idx;
                        we_d           = i_we[sel_idx];
                        wdata_d        = wdata_arr[sel_idx];
                        cmd_d          = {(i_we[sel_idx] ? 2'b10 : 2'b11), addr_arr[sel_idx]};
                        data_d         = {(i_we[sel_idx] ? 2'b10 : 2'b11), addr_arr[sel_idx]};
                        gnt_d[sel_idx] = 1'b1;
                        cnt_d          = '0;
                        state_d        = TXCMD;
                    end
                end
                TXCMD: begin
                    // A PHY turnaround aborts the TX CMD even when nxt is also high.
                    if (i_dir) begin
                        data_d  = '0;
                        state_d = RETRY;
                    end else if (i_nxt) begin
                        if (we_q) begin
                            data_d  = wdata_q;
                            state_d = WDATA;
                        end else begin
                            data_d  = '0;
                            state_d = RD_TURN;
                        end
                    end
                end
                WDATA: begin
                    if (i_nxt) begin
                        data_d  = '0;
                        stp_d   = 1'b1;
                        state_d = STP;
                    end
                end
                STP: begin
                    data_d  = '0;
                    state_d = DONE;
                end
                RD_TURN: begin
                    if (i_dir) begin
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: begin
                    rdbuf_d = i_data;
                    state_d = RD_TURN2;
                end
                RD_TURN2: begin
                    if (!i_dir) begin
                        state_d = DONE;
                    end
                end
                RETRY: begin
                    if (!i_dir) begin
                        data_d  = cmd_q;
                        cnt_d   = '0;
                        state_d = TXCMD;
                    end
                end
                DONE: begin
                    done_d[own_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d = rdbuf_q;
                    end
                    rr_d    = wrap_idx(own_q, 1);
                    state_d = IDLE;
                end
                default: begin
                    data_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            stp_q   <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stp_q   <= stp_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // Transaction operands are only meaningful once granted, so they carry no reset.
    always_ff @(posedge i_clk) begin
        own_q   <= own_d;
        we_q    <= we_d;
        cmd_q   <= cmd_d;
        wdata_q <= wdata_d;
        rdbuf_q <= rdbuf_d;
    end

    assign o_gnt   = gnt_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_busy  = busy_q;
    assign o_data  = data_q;
    assign o_stp   = stp_q;

endmodule

// File: tb/tb_ulpi_reg_arb.sv
// Directed bench for ulpi_reg_arb: write, read, round-robin, abort/retry,
// timeout and mid-transaction reset, with a PHY driven by hand-written vectors.
module tb_ulpi_reg_arb;
    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic        dir;
    logic        nxt;
    logic [7:0]  phy_data;
    logic [7:0]  link_data;
    logic        stp;

    int errors = 0;
    int checks = 0;

    ulpi_reg_arb #(.N_REQ(2), .TIMEOUT(8)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_req  (req),
        .i_we   (we),
        .i_addr (addr),
        .i_wdata(wdata),
        .o_gnt  (gnt),
        .o_done (done),
        .o_err  (err),
        .o_rdata(rdata),
        .o_busy (busy),
        .i_dir  (dir),
        .i_nxt  (nxt),
        .i_data (phy_data),
        .o_data (link_data),
        .o_stp  (stp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1ns after the edge; inputs set then are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; we = 2'b00; addr = '0; wdata = '0;
        dir = 1'b0; nxt = 1'b0; phy_data = '0;
        step();
        step();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL rst_done: got %b want 00", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (link_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", link_data); end
        checks++; if (stp !== 1'b0) begin errors++; $display("FAIL rst_stp: got %b want 0", stp); end
        req = 2'b00;
        rst = 1'b0;
        step();
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst: got gnt=%b busy=%b want 00/0", gnt, busy); end
    endtask

    task automatic test_write();
        req = 2'b01; we = 2'b01; addr = {6'h00, 6'h0A}; wdata = {8'h00, 8'h55};
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt); end
        checks++; if (link_data !== 8'h8A) begin errors++; $display("FAIL wr_txcmd: got %h want 8a", link_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        req = 2'b00;
        step();
        checks++; if (link_data !== 8'h8A || gnt !== 2'b00) begin errors++; $display("FAIL wr_txcmd_hold: got data=%h gnt=%b want 8a/00", link_data, gnt); end
        nxt = 1'b1;
        step();
        checks++; if (link_data !== 8'h55 || stp !== 1'b0) begin errors++; $display("FAIL wr_wdata: got data=%h stp=%b want 55/0", link_data, stp); end
        step();
        checks++; if (stp !== 1'b1 || link_data !== 8'h00) begin errors++; $display("FAIL wr_stp: got stp=%b data=%h want 1/00", stp, link_data); end
        nxt = 1'b0;
        step();
        checks++; if (stp !== 1'b0 || done !== 2'b00) begin errors++; $display("FAIL wr_stp_once: got stp=%b done=%b want 0/00", stp, done); end
        step();
        checks++; if (done !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL wr_done: got done=%b err=%b want 01/0", done, err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got busy=%b want 0", busy); end
        step();
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL wr_done_pulse: got %b want 00", done); end
    endtask

    task automatic test_read();
        logic stp_seen;
        stp_seen = 1'b0;
        req = 2'b10; we = 2'b00; addr = {6'h16, 6'h0A};
        step();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b want 10", gnt); end
        checks++; if (link_data !== 8'hD6) begin errors++; $display("FAIL rd_txcmd: got %h want d6", link_data); end
        stp_seen = stp_seen | stp;
        req = 2'b00; nxt = 1'b1;
        step();
        checks++; if (link_data !== 8'h00) begin errors++; $display("FAIL rd_turn_data: got %h want 00", link_data); end
        stp_seen = stp_seen | stp;
        nxt = 1'b0; dir = 1'b1;
        step();
        stp_seen = stp_seen | stp;
        phy_data = 8'hA3;
        step();
        stp_seen = stp_seen | stp;
        phy_data = 8'h00; dir = 1'b0;
        step();
        stp_seen = stp_seen | stp;
        step();
        stp_seen = stp_seen | stp;
        checks++; if (done !== 2'b10 || err !== 1'b0) begin errors++; $display("FAIL rd_done: got done=%b err=%b want 10/0", done, err); end
        checks++; if (rdata !== 8'hA3) begin errors++; $display("FAIL rd_rdata: got %h want a3", rdata); end
        checks++; if (stp_seen !== 1'b0) begin errors++; $display("FAIL rd_no_stp: got %b want 0", stp_seen); end
        step();
        checks++; if (rdata !== 8'hA3) begin errors++; $display("FAIL rd_rdata_hold: got %h want a3", rdata); end
    endtask

    task automatic test_round_robin();
        int         gidx [4];
        logic [7:0] gdat [4];
        int         gcount;
        int         n;
        gcount = 0;
        req = 2'b11; we = 2'b11; addr = {6'h31, 6'h0A}; wdata = {8'h11, 8'h22}; nxt = 1'b1;
        for (int c = 0; c < 60 && gcount < 4; c++) begin
            step();
            if (gnt !== 2'b00) begin
                gidx[gcount] = gnt[1] ? 1 : 0;
                gdat[gcount] = link_data;
                gcount++;
                if (gcount == 4) req = 2'b00;
            end
        end
        checks++; if (gcount !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", gcount); end
        for (int i = 0; i < gcount; i++) begin
            checks++; if (gidx[i] !== (i % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gidx[i], i % 2); end
            checks++; if (gdat[i] !== ((i % 2 == 0) ? 8'h8A : 8'hB1)) begin errors++; $display("FAIL rr_txcmd[%0d]: got %h want %h", i, gdat[i], (i % 2 == 0) ? 8'h8A : 8'hB1); end
        end
        req = 2'b00;
        n = 0;
        while (done === 2'b00 && n < 20) begin step(); n++; end
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL rr_last_done: got %b want 10", done); end
        nxt = 1'b0;
    endtask

    task automatic test_abort();
        int gnt_extra;
        gnt_extra = 0;
        req = 2'b01; we = 2'b01; addr = {6'h31, 6'h3F}; wdata = {8'h11, 8'hC3};
        step();
        checks++; if (gnt !== 2'b01 || link_data !== 8'hBF) begin errors++; $display("FAIL ab_gnt: got gnt=%b data=%h want 01/bf", gnt, link_data); end
        req = 2'b00; dir = 1'b1; nxt = 1'b1;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (link_data !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL ab_retry: got data=%h busy=%b want 00/1", link_data, busy); end
        nxt = 1'b0;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (link_data !== 8'h00) begin errors++; $display("FAIL ab_retry_hold: got %h want 00", link_data); end
        dir = 1'b0;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (link_data !== 8'hBF) begin errors++; $display("FAIL ab_reissue: got %h want bf", link_data); end
        nxt = 1'b1;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (link_data !== 8'hC3) begin errors++; $display("FAIL ab_wdata: got %h want c3", link_data); end
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (stp !== 1'b1) begin errors++; $display("FAIL ab_stp: got %b want 1", stp); end
        nxt = 1'b0;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        step();
        if (gnt !== 2'b00) gnt_extra++;
        checks++; if (done !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL ab_done: got done=%b err=%b want 01/0", done, err); end
        checks++; if (gnt_extra !== 0) begin errors++; $display("FAIL ab_no_regrant: got %0d extra grants want 0", gnt_extra); end
    endtask

    task automatic test_timeout();
        int n;
        req = 2'b10; we = 2'b00; addr = {6'h05, 6'h3F};
        step();
        checks++; if (gnt !== 2'b10 || link_data !== 8'hC5) begin errors++; $display("FAIL to_gnt: got gnt=%b data=%h want 10/c5", gnt, link_data); end
        req = 2'b00; nxt = 1'b0; dir = 1'b0;
        n = 0;
        while (done === 2'b00 && n < 20) begin step(); n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL to_latency: got %0d cycles want 8", n); end
        checks++; if (done !== 2'b10 || err !== 1'b1) begin errors++; $display("FAIL to_done: got done=%b err=%b want 10/1", done, err); end
        checks++; if (link_data !== 8'h00 || stp !== 1'b0) begin errors++; $display("FAIL to_bus: got data=%h stp=%b want 00/0", link_data, stp); end
        step();
        checks++; if (busy !== 1'b0 || done !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL to_after: got busy=%b done=%b err=%b want 0/00/0", busy, done, err); end
    endtask

    task automatic test_reset_mid();
        int n;
        req = 2'b01; we = 2'b11; addr = {6'h31, 6'h0A}; wdata = {8'h7E, 8'h55};
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_pre_gnt: got %b want 01", gnt); end
        req = 2'b00; nxt = 1'b1;
        n = 0;
        while (done === 2'b00 && n < 20) begin step(); n++; end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL rm_pre_done: got %b want 01", done); end
        req = 2'b10; nxt = 1'b0;
        step();
        checks++; if (gnt !== 2'b10 || link_data !== 8'hB1) begin errors++; $display("FAIL rm_gnt1: got gnt=%b data=%h want 10/b1", gnt, link_data); end
        req = 2'b00; nxt = 1'b1;
        step();
        checks++; if (link_data !== 8'h7E) begin errors++; $display("FAIL rm_wdata: got %h want 7e", link_data); end
        nxt = 1'b0;
        step();
        rst = 1'b1; req = 2'b11;
        step();
        rst = 1'b0;
        checks++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 1'b0 || busy !== 1'b0 || stp !== 1'b0 || link_data !== 8'h00 || rdata !== 8'h00) begin
            errors++; $display("FAIL rm_outputs: got gnt=%b done=%b err=%b busy=%b stp=%b data=%h rdata=%h want all 0", gnt, done, err, busy, stp, link_data, rdata);
        end
        step();
        checks++; if (gnt !== 2'b01 || done !== 2'b00) begin errors++; $display("FAIL rm_regrant: got gnt=%b done=%b want 01/00", gnt, done); end
        req = 2'b00; nxt = 1'b1;
        n = 0;
        while (done === 2'b00 && n < 20) begin step(); n++; end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL rm_done: got %b want 01", done); end
        nxt = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
